// File: rtl/pc_pkg.sv
// pc_pkg: shared op codes, FSM state type and PC width for the program-counter sequencer.
`default_nettype none

package pc_pkg;

    localparam int PC_W = 15;

    localparam logic [3:0] COU_JEQ  = 4'd1;
    localparam logic [3:0] COU_JGT  = 4'd2;
    localparam logic [3:0] COU_JLT  = 4'd3;
    localparam logic [3:0] COU_JMP  = 4'd5;
    localparam logic [3:0] COU_NEXT = 4'd6;
    localparam logic [3:0] COU_CALL = 4'd7;
    localparam logic [3:0] COU_RET  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_ISSUE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: synchronous LIFO holding CALL return addresses.
`default_nettype none

module pc_ret_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [AW-1:0] w_top;

    assign w_top = r_ptr[AW-1:0] - AW'(1);
    assign dout  = r_mem[w_top];
    assign full  = (r_ptr == PW'(DEPTH));
    assign empty = (r_ptr == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (push && !full) begin
            r_ptr <= r_ptr + PW'(1);
        end else if (pop && !empty) begin
            r_ptr <= r_ptr - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            r_mem[r_ptr[AW-1:0]] <= din;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// pc_sequencer: resolves COU commands (jumps, CALL/RET) into a new fetch address.
// Build option: define PC_SIGNED_CMP_EN for two's-complement JGT/JLT compares.
`default_nettype none

module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              STACK_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC    = 15'd0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sCOU,
    input  logic [3:0]      mOperCOU,
    input  logic [PC_W-1:0] dataAddr,
    input  logic [1:0]      creg1,
    input  logic [1:0]      creg2,
    input  logic            aeq,
    input  logic [63:0]     regs,
    output logic [PC_W-1:0] pc,
    output logic            fetch,
    output logic            busy,
    output logic            err,
    output logic            ovf,
    output logic            unf
);

    state_t          r_state;
    logic [3:0]      r_op;
    logic [PC_W-1:0] r_addr;
    logic [1:0]      r_sel1;
    logic [1:0]      r_sel2;
    logic            r_aeq;
    logic [PC_W-1:0] r_next_pc;
    logic            r_push;
    logic            r_pop;
    logic            r_illegal;
    logic            r_set_ovf;
    logic            r_set_unf;

    logic [15:0]     w_a;
    logic [15:0]     w_b;
    logic            w_gt;
    logic            w_lt;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_next;
    logic            w_push;
    logic            w_pop;
    logic            w_ill;
    logic            w_ovf;
    logic            w_unf;
    logic [PC_W-1:0] w_stk_dout;
    logic            w_stk_full;
    logic            w_stk_empty;

    assign busy     = (r_state != ST_IDLE);
    assign w_pc_inc = pc + PC_W'(1);
    assign w_a      = regs[{r_sel1, 4'b0000} +: 16];
    assign w_b      = regs[{r_sel2, 4'b0000} +: 16];

`ifdef PC_SIGNED_CMP_EN
    assign w_gt = $signed(w_a) > $signed(w_b);
    assign w_lt = $signed(w_a) < $signed(w_b);
`else
    assign w_gt = w_a > w_b;
    assign w_lt = w_a < w_b;
`endif

    // Next-PC and stack decision, valid while in ACCEPT (regs sampled here).
    always_comb begin
        w_next = w_pc_inc;
        w_push = 1'b0;
        w_pop  = 1'b0;
        w_ill  = 1'b0;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        case (r_op)
            COU_JEQ:  if (w_a == w_b) w_next = r_addr;
            COU_JGT:  if (w_gt || (r_aeq && w_a == w_b)) w_next = r_addr;
            COU_JLT:  if (w_lt || (r_aeq && w_a == w_b)) w_next = r_addr;
            COU_JMP:  w_next = r_addr;
            COU_NEXT: w_next = w_pc_inc;
            COU_CALL: begin
                if (w_stk_full) begin
                    w_ovf = 1'b1;
                end else begin
                    w_push = 1'b1;
                    w_next = r_addr;
                end
            end
            COU_RET: begin
                if (w_stk_empty) begin
                    w_unf = 1'b1;
                end else begin
                    w_pop  = 1'b1;
                    w_next = w_stk_dout;
                end
            end
            default: begin
                w_ill  = 1'b1;
                w_next = pc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_addr    <= '0;
            r_sel1    <= '0;
            r_sel2    <= '0;
            r_aeq     <= 1'b0;
            r_next_pc <= '0;
            r_push    <= 1'b0;
            r_pop     <= 1'b0;
            r_illegal <= 1'b0;
            r_set_ovf <= 1'b0;
            r_set_unf <= 1'b0;
            pc        <= RESET_PC;
            fetch     <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            fetch <= 1'b0;
            err   <= 1'b0;
            // A strobe while a command is in flight is dropped.
            if (sCOU && r_state != ST_IDLE) err <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (sCOU) begin
                        r_op    <= mOperCOU;
                        r_addr  <= dataAddr;
                        r_sel1  <= creg1;
                        r_sel2  <= creg2;
                        r_aeq   <= aeq;
                        r_state <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    r_next_pc <= w_next;
                    r_push    <= w_push;
                    r_pop     <= w_pop;
                    r_illegal <= w_ill;
                    r_set_ovf <= w_ovf;
                    r_set_unf <= w_unf;
                    r_state   <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    pc      <= r_next_pc;
                    fetch   <= 1'b1;
                    if (r_illegal) err <= 1'b1;
                    if (r_set_ovf) ovf <= 1'b1;
                    if (r_set_unf) unf <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    pc_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  ((r_state == ST_ISSUE) && r_push),
        .pop   ((r_state == ST_ISSUE) && r_pop),
        .din   (w_pc_inc),
        .dout  (w_stk_dout),
        .full  (w_stk_full),
        .empty (w_stk_empty)
    );

endmodule

`default_nettype wire
